// File: rtl/pal_test_pattern.sv
`default_nettype none
// ============================================================================
// Module   : pal_test_pattern
// Brief    : PAL test pattern generator (bars / composite / ramp / scroll) with
//            a fixed PIPE_DELAY output pipeline. Define PAL_TEST_PATTERN_SCROLL_EN
//            to build the scrolling mode 3; otherwise mode 3 renders as bars.
// Revision : 1.0 - initial release
// ============================================================================
module pal_test_pattern #(
    parameter int PIXEL_WIDTH  = 9,
    parameter int ACTIVE_START = 77,
    parameter int ACTIVE_WIDTH = 770,
    parameter int NUM_BARS     = 7,
    parameter int PIPE_DELAY   = 2
) (
    input  logic                          palClock,
    input  logic                          reset,
    input  logic [9:0]                    hPos,
    input  logic [9:0]                    vPos,
    input  logic                          blank,
    input  logic                          sync,
    input  logic                          burst,
    input  logic                          burstPhase,
    input  logic [1:0]                    modeSel,
    input  logic                          modeLoad,
    output logic signed [PIXEL_WIDTH-1:0] y,
    output logic signed [PIXEL_WIDTH-1:0] u,
    output logic signed [PIXEL_WIDTH-1:0] v,
    output logic                          blankDelayed,
    output logic                          syncDelayed,
    output logic                          burstDelayed,
    output logic                          burstPhaseDelayed,
    output logic [1:0]                    modeActive
);

    localparam int BAR_WIDTH = ACTIVE_WIDTH / NUM_BARS;
    localparam int PIX_W     = $clog2(BAR_WIDTH) + 1;
    localparam int STAGE_W   = 3 * PIXEL_WIDTH + 6;

    localparam logic [9:0]       ACT_START  = 10'(ACTIVE_START);
    localparam logic [9:0]       V_REVERSE  = 10'd383;
    localparam logic [9:0]       V_PLUGE    = 10'd440;
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(BAR_WIDTH - 1);
    localparam logic [PIX_W-1:0] PIX_HALF   = PIX_W'(BAR_WIDTH / 2);
    localparam logic [2:0]       BAR_LAST   = 3'(NUM_BARS - 1);
    localparam logic [2:0]       BAR_PENULT = 3'(NUM_BARS - 2);

    localparam logic [1:0] MODE_BARS      = 2'd0;
    localparam logic [1:0] MODE_COMPOSITE = 2'd1;
    localparam logic [1:0] MODE_RAMP      = 2'd2;
    localparam logic [1:0] MODE_SCROLL    = 2'd3;

    localparam logic [STAGE_W-1:0] STAGE_RESET = {{(3 * PIXEL_WIDTH){1'b0}}, 4'b1000, 2'b00};
    localparam logic [PIPE_DELAY*STAGE_W-1:0] PIPE_RESET = {PIPE_DELAY{STAGE_RESET}};

    logic [PIX_W-1:0] pix_q, pix_d, pix_cur;
    logic [2:0]       bar_q, bar_d, bar_cur;
    logic [7:0]       ramp_q, ramp_d, ramp_cur;
    logic [1:0]       mode_q, mode_d, pending_q, pending_d;
    logic             line_start, pre_active, frame_start;
    logic [2:0]       scroll_idx, colour_idx;

    logic signed [PIXEL_WIDTH-1:0] tab_y, tab_u, tab_v;
    logic signed [PIXEL_WIDTH-1:0] px_y, px_u, px_v;

    logic [STAGE_W-1:0]            stage_d;
    logic [PIPE_DELAY*STAGE_W-1:0] pipe_q, pipe_d;

    // Counter values belong to the pixel on the input this cycle; *_d is the next pixel.
    always_comb begin
        line_start  = (hPos == ACT_START);
        pre_active  = (hPos < ACT_START);
        frame_start = (hPos == 10'd0) && (vPos == 10'd0);

        pix_cur  = line_start ? '0 : pix_q;
        bar_cur  = line_start ? '0 : bar_q;
        ramp_cur = line_start ? '0 : ramp_q;

        if (pix_cur == PIX_LAST) begin
            pix_d = '0;
            bar_d = (bar_cur == BAR_LAST) ? bar_cur : bar_cur + 3'd1;
        end else begin
            pix_d = pix_cur + 1'b1;
            bar_d = bar_cur;
        end
        ramp_d = (ramp_cur == 8'hFF) ? ramp_cur : ramp_cur + 8'd1;

        pending_d = modeLoad ? modeSel : pending_q;
        mode_d    = frame_start ? pending_d : mode_q;
    end

`ifdef PAL_TEST_PATTERN_SCROLL_EN
    logic [2:0] scroll_q, scroll_d;
    logic [3:0] scroll_sum;

    always_comb begin
        scroll_d = scroll_q;
        if (frame_start) begin
            if (mode_d != mode_q) begin
                scroll_d = '0;
            end else if (mode_q == MODE_SCROLL) begin
                scroll_d = (scroll_q == BAR_LAST) ? 3'd0 : scroll_q + 3'd1;
            end
        end
        // Both terms are below NUM_BARS, so one conditional subtract is the modulo.
        scroll_sum = {1'b0, bar_cur} + {1'b0, scroll_d};
        scroll_idx = (scroll_sum >= 4'(NUM_BARS)) ? 3'(scroll_sum - 4'(NUM_BARS))
                                                  : scroll_sum[2:0];
    end

    always_ff @(posedge palClock or posedge reset) begin
        if (reset) begin
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_d;
        end
    end
`else
    assign scroll_idx = bar_cur;
`endif

    always_comb begin
        colour_idx = 3'd0;
        if (!pre_active) begin
            case (mode_d)
                MODE_COMPOSITE: begin
                    if (vPos >= V_REVERSE) begin
                        colour_idx = bar_cur[0] ? 3'd7 : BAR_LAST - bar_cur;
                    end else begin
                        colour_idx = bar_cur;
                    end
                end
                MODE_SCROLL: colour_idx = scroll_idx;
                default:     colour_idx = bar_cur;
            endcase
        end
    end

    always_comb begin
        tab_y = '0;
        tab_u = '0;
        tab_v = '0;
        case (colour_idx)
            3'd0: tab_y = PIXEL_WIDTH'(235);
            3'd1: begin tab_y = PIXEL_WIDTH'(169); tab_u = PIXEL_WIDTH'(-83); tab_v = PIXEL_WIDTH'(19);   end
            3'd2: begin tab_y = PIXEL_WIDTH'(134); tab_u = PIXEL_WIDTH'(28);  tab_v = PIXEL_WIDTH'(-117); end
            3'd3: begin tab_y = PIXEL_WIDTH'(112); tab_u = PIXEL_WIDTH'(-55); tab_v = PIXEL_WIDTH'(-98);  end
            3'd4: begin tab_y = PIXEL_WIDTH'(79);  tab_u = PIXEL_WIDTH'(55);  tab_v = PIXEL_WIDTH'(98);   end
            3'd5: begin tab_y = PIXEL_WIDTH'(57);  tab_u = PIXEL_WIDTH'(-28); tab_v = PIXEL_WIDTH'(117);  end
            3'd6: begin tab_y = PIXEL_WIDTH'(22);  tab_u = PIXEL_WIDTH'(83);  tab_v = PIXEL_WIDTH'(-19);  end
            default: ;
        endcase
    end

    always_comb begin
        px_y = tab_y;
        px_u = tab_u;
        px_v = tab_v;
        if (mode_d == MODE_RAMP) begin
            px_y = pre_active ? '0 : PIXEL_WIDTH'(ramp_cur);
            px_u = '0;
            px_v = '0;
        end else if ((mode_d == MODE_COMPOSITE) && !pre_active && (vPos >= V_PLUGE)) begin
            px_u = '0;
            px_v = '0;
            if (bar_cur == 3'd1) begin
                px_y = PIXEL_WIDTH'(255);
            end else if ((bar_cur == BAR_PENULT) && (pix_cur < PIX_HALF)) begin
                px_y = PIXEL_WIDTH'(-10);
            end else begin
                px_y = '0;
            end
        end
        if (blank) begin
            px_y = '0;
            px_u = '0;
            px_v = '0;
        end
    end

    assign stage_d = {px_y, px_u, px_v, blank, sync, burst, burstPhase, mode_d};

    if (PIPE_DELAY == 1) begin : g_pipe_single
        assign pipe_d = stage_d;
    end else begin : g_pipe_multi
        assign pipe_d = {pipe_q[(PIPE_DELAY-1)*STAGE_W-1:0], stage_d};
    end

    always_ff @(posedge palClock or posedge reset) begin
        if (reset) begin
            pix_q     <= '0;
            bar_q     <= '0;
            ramp_q    <= '0;
            mode_q    <= MODE_BARS;
            pending_q <= MODE_BARS;
            pipe_q    <= PIPE_RESET;
        end else begin
            pix_q     <= pix_d;
            bar_q     <= bar_d;
            ramp_q    <= ramp_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            pipe_q    <= pipe_d;
        end
    end

    assign {y, u, v, blankDelayed, syncDelayed, burstDelayed, burstPhaseDelayed, modeActive} =
        pipe_q[PIPE_DELAY*STAGE_W-1 -: STAGE_W];

endmodule
`default_nettype wire

// File: doc/pal_test_pattern.md
PAL_TEST_PATTERN -- requirements
Module: pal_test_pattern

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 9: signed y/u/v width; legal range 9..12.
REQ-002 SHALL have parameter ACTIVE_START, default 77: hPos of the first active pixel.
REQ-003 SHALL have parameter ACTIVE_WIDTH, default 770: active pixels per line.
REQ-004 SHALL have parameter NUM_BARS, default 7: bar count; legal range 2..8.
REQ-005 SHALL have parameter PIPE_DELAY, default 2: input-to-output latency in cycles; legal range 1..4.
REQ-006 SHALL have port palClock, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports hPos and vPos, inputs, 10 bits each: raster position.
REQ-009 SHALL have ports blank, sync, burst and burstPhase, inputs, 1 bit each: timing strobes.
REQ-010 SHALL have ports modeSel, input, 2 bits, and modeLoad, input, 1 bit: requested mode and its load strobe.
REQ-011 SHALL have ports y, u and v, outputs, signed, PIXEL_WIDTH bits each: component video.
REQ-012 SHALL have ports blankDelayed, syncDelayed, burstDelayed and burstPhaseDelayed, outputs, 1 bit each: the aligned strobes.
REQ-013 SHALL have port modeActive, output, 2 bits: the mode currently rendered.

Function
REQ-014 SHALL delay every output by exactly PIPE_DELAY cycles from the inputs that produced it, with video and strobes aligned.
REQ-015 SHALL force y/u/v to 0 on any output cycle where blankDelayed is 1.
REQ-016 SHALL use BAR_WIDTH = ACTIVE_WIDTH/NUM_BARS (integer division, elaboration constant) and no runtime divider.
REQ-017 SHALL count pixels within a bar as 0..BAR_WIDTH-1 and bar index as 0..NUM_BARS-1, both cleared at hPos==ACTIVE_START.
REQ-018 SHALL advance the bar index when the pixel count wraps, and hold the index at NUM_BARS-1 until line end.
REQ-019 SHALL use colour table index 0..7 = white 235/0/0, yellow 169/-83/19, cyan 134/28/-117, green 112/-55/-98, magenta 79/55/98, red 57/-28/117, blue 22/83/-19, black 0/0/0 (y/u/v).
REQ-020 SHALL sign-extend table constants to PIXEL_WIDTH.
REQ-021 SHALL render the pre-active area as index 0 in modes 0, 1 and 3.
REQ-022 Mode 0 (bars) SHALL output the colour at the bar index.
REQ-023 Mode 1 (composite) SHALL match mode 0 for vPos<383.
REQ-024 Mode 1 SHALL, for 383<=vPos<440, output reverse bars in even slots (blue, magenta, cyan, white at slots 0/2/4/6 for NUM_BARS=7) and black in odd slots.
REQ-025 Mode 1 SHALL, for vPos>=440, output black except: y=255 u=v=0 on bar index 1, and y=-10 on the first half of the second-to-last bar.
REQ-026 Mode 2 (ramp) SHALL set u=v=0 and y=0 at ACTIVE_START, incrementing y by 1 per pixel and saturating at 255.
REQ-027 Mode 3 (scroll) SHALL output colour index (barIndex+scrollOffset) mod NUM_BARS.
REQ-028 SHALL hold scrollOffset in 0..NUM_BARS-1, incrementing once per frame boundary while modeActive==3 and wrapping NUM_BARS-1 -> 0.
REQ-029 SHALL define the frame boundary as the cycle with hPos==0 and vPos==0.
REQ-030 SHALL register modeSel into a pending register on the cycle modeLoad==1; the last load before a boundary wins.
REQ-031 SHALL copy pending into modeActive at each frame boundary and never change modeActive mid-frame.
REQ-032 SHALL apply a modeLoad coincident with a frame boundary at that same boundary.
REQ-033 SHALL clear scrollOffset on any change of modeActive.

Reset
REQ-034 SHALL, while reset==1, drive y=u=v=0, blankDelayed=1 and the other delayed strobes 0.
REQ-035 SHALL, while reset==1, clear modeActive, pending, scrollOffset, the pixel/bar counters and all pipeline stages (strobe stages to the reset output values).
REQ-036 SHALL, on reset release mid-frame, render mode 0 from the current position, with outputs valid PIPE_DELAY cycles later.

Configuration
REQ-037 SHALL, with PAL_TEST_PATTERN_SCROLL_EN defined, implement mode 3 as specified.
REQ-038 SHALL, without PAL_TEST_PATTERN_SCROLL_EN, render mode 3 identically to mode 0, omit the scrollOffset logic, and still report modeActive==3.

Verification
REQ-039 Reset: assert reset mid-line -> next cycle y=u=v=0, blankDelayed=1, modeActive=0.
REQ-040 Latency: PIPE_DELAY=3, mode 0, hPos steps 186->187 -> y changes 235->169 exactly 3 cycles later; blankDelayed aligned.
REQ-041 Mode switch: modeSel=2 plus modeLoad at vPos=100 -> modeActive stays 0 until hPos=vPos=0, then 2; at ACTIVE_START+300, y=255.
REQ-042 Coincident load: modeLoad with modeSel=1 on the boundary cycle -> modeActive=1 that frame; vPos=450, bar 1 -> y=255.
REQ-043 Scroll: mode 3, NUM_BARS=7, over 8 frames -> bar 0 colour cycles through indices 0,1,..,6,0; with the macro undefined, it stays white.
REQ-044 Blank: blank=1 during active mode 0 -> y=u=v=0 for those output cycles.
